// File: rtl/regfile_dumper_pkg.sv
// regfile_dump_pkg
// Shared definitions for the register-file debug dumper and the CPU-side
// read-port mux that hands the regfile read port to the dumper while busy.
//   dump_state_t : dumper FSM states
//   RF_NREGS     : number of architectural registers
//   RF_AW        : register address width
package regfile_dump_pkg;

  localparam int RF_NREGS = 32;
  localparam int RF_AW    = 5;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    DRAIN = 3'd1,
    READ  = 3'd2,
    SEND  = 3'd3,
    DONE  = 3'd4
  } dump_state_t;

endpackage

// File: rtl/regfile_dumper.sv
// regfile_dumper
// Debug reader for the register file. A start pulse freezes architectural
// writes (stall_req), walks addresses 0..NREGS-1 through one combinational
// regfile read port and streams (address, data) beats over valid/ready.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   start           one-cycle dump request, ignored while busy
//   busy            dumper owns the regfile read port (DRAIN..DONE)
//   stall_req       CPU must hold its regfile write enable low
//   done            one-cycle pulse after the last beat is accepted
//   rf_readaddr     regfile read address (0 when not reading)
//   rf_readdata     regfile read data, same-cycle
//   out_valid/ready stream handshake
//   out_addr        register index of the current beat
//   out_data        captured register value
module regfile_dumper
  import regfile_dump_pkg::*;
#(
  parameter int NREGS = RF_NREGS,
  parameter int DW    = 32,
  parameter int AW    = RF_AW
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  output logic          busy,
  output logic          stall_req,
  output logic          done,
  output logic [AW-1:0] rf_readaddr,
  input  logic [DW-1:0] rf_readdata,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [AW-1:0] out_addr,
  output logic [DW-1:0] out_data
);

  dump_state_t   state;
  dump_state_t   nxt;
  logic [AW-1:0] idx;
  logic          hs;
  logic          last;

  // out_valid is exactly "state is SEND", so the handshake only needs ready.
  assign hs   = (state == SEND) && out_ready;
  assign last = (idx == AW'(NREGS - 1));

  // Read port is driven only while reading so the CPU mux sees a quiet bus.
  assign rf_readaddr = (state == READ) ? idx : '0;

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (start) nxt = DRAIN;
      DRAIN:   nxt = READ;
      READ:    nxt = SEND;
      SEND:    if (hs) nxt = last ? DONE : READ;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  // Status outputs are decoded from the next state and registered, so they
  // line up with the state register and are free of decode glitches.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      idx       <= '0;
      busy      <= 1'b0;
      stall_req <= 1'b0;
      done      <= 1'b0;
      out_valid <= 1'b0;
      out_addr  <= '0;
      out_data  <= '0;
    end else begin
      state     <= nxt;
      busy      <= (nxt != IDLE);
      stall_req <= (nxt == DRAIN) || (nxt == READ) || (nxt == SEND);
      done      <= (nxt == DONE);
      out_valid <= (nxt == SEND);

      // idx stops at NREGS-1: the terminal compare leaves SEND for DONE
      // instead of incrementing, so it never wraps.
      if (state == DRAIN)
        idx <= '0;
      else if (hs && !last)
        idx <= idx + 1'b1;

      // Capture once per beat; held through SEND until the handshake.
      if (state == READ) begin
        out_addr <= idx;
        out_data <= rf_readdata;
      end
    end
  end

endmodule

// File: tb/tb_regfile_dumper.sv
// tb_regfile_dumper
// Directed bench for regfile_dumper: a small regfile model with a CPU-style
// write port feeds the dumper; each dump is walked cycle by cycle on the
// falling edge and every beat is compared with hand-derived register values.
module tb_regfile_dumper;
  import regfile_dump_pkg::*;

  localparam int NREGS = RF_NREGS;
  localparam int DW    = 32;
  localparam int AW    = RF_AW;

  logic          clk;
  logic          rst;
  logic          start;
  logic          busy;
  logic          stall_req;
  logic          done;
  logic [AW-1:0] rf_readaddr;
  logic [DW-1:0] rf_readdata;
  logic          out_valid;
  logic          out_ready;
  logic [AW-1:0] out_addr;
  logic [DW-1:0] out_data;

  // Regfile environment: x0 hardwired to zero, one synchronous write port.
  logic [DW-1:0] rf [1:NREGS-1];
  logic          we;
  logic [AW-1:0] waddr;
  logic [DW-1:0] wdata;

  always @(posedge clk) if (we && waddr != '0) rf[waddr] <= wdata;
  assign rf_readdata = (rf_readaddr == '0) ? '0 : rf[rf_readaddr];

  regfile_dumper #(.NREGS(NREGS), .DW(DW), .AW(AW)) dut (
    .clk        (clk),
    .rst        (rst),
    .start      (start),
    .busy       (busy),
    .stall_req  (stall_req),
    .done       (done),
    .rf_readaddr(rf_readaddr),
    .rf_readdata(rf_readdata),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_addr   (out_addr),
    .out_data   (out_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int            checks = 0;
  int            errors = 0;
  logic [DW-1:0] exp_rf [NREGS];
  logic [DW-1:0] got    [NREGS];
  int            beats, ndone, done_at, first_v, stalls;
  bit            stall_bad, hold_bad, aborted;
  int            pat [4] = '{1, 0, 0, 1};

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Runs one dump. bp: 1,0,0,1 backpressure; wr7: CPU writes x7 in the cycle
  // start is sampled; repulse: start re-pulsed during beats 3 and 31;
  // abort_at: assert rst while that address is in SEND (-1 = never).
  // Falling edge n after the start-sampling edge is spec cycle N+n.
  task automatic run_dump(input string name, input bit bp, input bit wr7,
                          input bit repulse, input int abort_at);
    bit            pend;
    logic [AW-1:0] pa;
    logic [DW-1:0] pd;
    pend = 0; pa = '0; pd = '0;
    beats = 0; ndone = 0; done_at = -1; first_v = -1; stalls = 0;
    stall_bad = 0; hold_bad = 0; aborted = 0;
    @(negedge clk);
    chk({name, "_idle_busy"}, 32'(busy), 32'd0);
    chk({name, "_idle_raddr"}, 32'(rf_readaddr), 32'd0);
    start = 1'b1;
    out_ready = 1'b1;
    if (wr7) begin
      we = 1'b1; waddr = 5'd7; wdata = 32'hDEAD_BEEF;
      exp_rf[7] = 32'hDEAD_BEEF;
    end
    for (int n = 1; n <= 400; n++) begin
      @(negedge clk);
      start = 1'b0;
      we = 1'b0;
      if (done) begin
        ndone++;
        if (done_at < 0) done_at = n;
        if (stall_req !== 1'b0 || busy !== 1'b1) stall_bad = 1;
      end else if (busy) begin
        if (stall_req !== 1'b1) stall_bad = 1;
      end
      if (out_valid && first_v < 0) first_v = n;
      if (pend && (out_valid !== 1'b1 || out_addr !== pa || out_data !== pd)) hold_bad = 1;
      if (abort_at >= 0 && out_valid && 32'(out_addr) == 32'(abort_at)) begin
        rst = 1'b1;
        out_ready = 1'b0;
        @(negedge clk);
        chk({name, "_abort_valid"}, 32'(out_valid), 32'd0);
        chk({name, "_abort_stall"}, 32'(stall_req), 32'd0);
        chk({name, "_abort_busy"}, 32'(busy), 32'd0);
        chk({name, "_abort_done"}, 32'(done), 32'd0);
        rst = 1'b0;
        aborted = 1;
        break;
      end
      out_ready = bp ? pat[n % 4][0] : 1'b1;
      if (repulse && out_valid && !pend && (out_addr == 5'd3 || out_addr == 5'd31))
        start = 1'b1;
      if (out_valid && out_ready) begin
        if (beats < NREGS) begin
          chk($sformatf("%s_beat%0d_addr", name, beats), 32'(out_addr), 32'(beats));
          chk($sformatf("%s_beat%0d_data", name, beats), out_data, exp_rf[beats]);
          got[beats] = out_data;
        end
        beats++;
        pend = 0;
      end else begin
        if (out_valid) stalls++;
        pend = out_valid;
        pa = out_addr;
        pd = out_data;
      end
      if (done_at > 0 && n >= done_at + 4) break;
    end
    out_ready = 1'b1;
    if (abort_at < 0) begin
      chk({name, "_beats"}, 32'(beats), 32'(NREGS));
      chk({name, "_ndone"}, 32'(ndone), 32'd1);
      chk({name, "_first_valid"}, 32'(first_v), 32'd3);
      chk({name, "_done_cycle"}, 32'(done_at), 32'(66 + stalls));
      chk({name, "_stall_req"}, 32'(stall_bad), 32'd0);
      chk({name, "_hold"}, 32'(hold_bad), 32'd0);
    end else begin
      chk({name, "_aborted"}, 32'(aborted), 32'd1);
    end
  endtask

  initial begin
    rst = 1'b1; start = 1'b0; out_ready = 1'b0;
    we = 1'b0; waddr = '0; wdata = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_stall", 32'(stall_req), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_valid", 32'(out_valid), 32'd0);
    chk("rst_addr", 32'(out_addr), 32'd0);
    chk("rst_data", out_data, 32'd0);
    chk("rst_raddr", 32'(rf_readaddr), 32'd0);
    rst = 1'b0;

    // Preload through the write port; x5/x6 hold the test-plan values.
    exp_rf[0] = 32'd0;
    for (int i = 1; i < NREGS; i++) begin
      exp_rf[i] = 32'h5000_0000 + 32'(i) * 32'h0000_0101;
      if (i == 5) exp_rf[i] = 32'h0000_00AA;
      if (i == 6) exp_rf[i] = 32'h1234_5678;
      we = 1'b1; waddr = AW'(i); wdata = exp_rf[i];
      @(negedge clk);
    end
    we = 1'b0;
    // out_ready high while idle must not disturb anything.
    out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk("idle_ready_valid", 32'(out_valid), 32'd0);

    run_dump("full", 1'b0, 1'b0, 1'b0, -1);
    chk("full_x0", got[0], 32'h0000_0000);
    chk("full_x5", got[5], 32'h0000_00AA);
    chk("full_x6", got[6], 32'h1234_5678);

    run_dump("bp", 1'b1, 1'b0, 1'b0, -1);
    chk("bp_stalled", 32'(stalls > 0), 32'd1);

    run_dump("drain", 1'b0, 1'b1, 1'b0, -1);
    chk("drain_x7", got[7], 32'hDEAD_BEEF);

    run_dump("restart", 1'b0, 1'b0, 1'b1, -1);

    run_dump("abort", 1'b0, 1'b0, 1'b0, 10);
    repeat (2) @(negedge clk);
    chk("abort_no_done", 32'(done), 32'd0);
    run_dump("after_abort", 1'b0, 1'b0, 1'b0, -1);
    chk("after_abort_x0", got[0], 32'h0000_0000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
